// File: rtl/vga_cap_pkg.sv
// Shared state encoding, counter width and default 640x480 timing for vga_capture.
package vga_cap_pkg;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam int CW = 11;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_MAX = '1;

  localparam int H_ACT_DEF   = 640;
  localparam int V_ACT_DEF   = 480;
  localparam int X_START_DEF = 144;
  localparam int Y_START_DEF = 35;

endpackage

// File: rtl/vga_edge_detect.sv
// Registers an active-low sync and pulses on its registered 1->0 transition.
// Latency 1 clock to the pulse; no backpressure.
module vga_edge_detect (
  input  logic mCLK,
  input  logic iRST_N,
  input  logic sync,
  output logic fall
);

  logic s1, s1_d;

  // Reset to the inactive level so reset release never looks like an edge.
  always_ff @(posedge mCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      s1   <= 1'b1;
      s1_d <= 1'b1;
    end else begin
      s1   <= sync;
      s1_d <= s1;
    end
  end

  assign fall = s1_d & ~s1;

endmodule

// File: rtl/vga_capture.sv
// Locks onto VGA sync timing and emits active-area pixels with coordinates and linear address.
// Latency 2 clocks from input sample to oPix_*; no backpressure (pixel-rate stream).
module vga_capture
  import vga_cap_pkg::*;
#(
  parameter int H_ACT       = H_ACT_DEF,
  parameter int V_ACT       = V_ACT_DEF,
  parameter int X_START     = X_START_DEF,
  parameter int Y_START     = Y_START_DEF,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        mCLK,
  input  logic        iRST_N,
  input  logic        iVGA_H_SYNC,
  input  logic        iVGA_V_SYNC,
  input  logic [9:0]  iVGA_R,
  input  logic [9:0]  iVGA_G,
  input  logic [9:0]  iVGA_B,
  output logic [9:0]  oPix_R,
  output logic [9:0]  oPix_G,
  output logic [9:0]  oPix_B,
  output logic        oPix_Valid,
  output logic [9:0]  oCoord_X,
  output logic [9:0]  oCoord_Y,
  output logic [18:0] oAddress,
  output logic        oFrame_Start,
  output logic        oLocked,
  output logic [10:0] oH_Total,
  output logic [10:0] oV_Total
);

  localparam cnt_t        X_LO     = cnt_t'(X_START);
  localparam cnt_t        X_HI     = cnt_t'(X_START + H_ACT);
  localparam cnt_t        Y_LO     = cnt_t'(Y_START);
  localparam cnt_t        Y_HI     = cnt_t'(Y_START + V_ACT);
  localparam logic [7:0]  LOCK_N   = 8'(LOCK_FRAMES);
  localparam logic [18:0] ADDR_MAX = 19'(H_ACT * V_ACT - 1);

  logic        h_edge, v_edge, v_restart, v_pend;
  logic        h_sat, v_sat, frame_ok, fault, in_win, pix_ok, first;
  cnt_t        h_cnt, v_cnt, h_per, v_per, ref_h, ref_v;
  logic [9:0]  x_c, y_c;
  logic [29:0] rgb_s1, rgb_s2;
  logic [7:0]  good;
  logic        ref_vld;
  state_t      state;

  vga_edge_detect u_h_edge (.mCLK(mCLK), .iRST_N(iRST_N), .sync(iVGA_H_SYNC), .fall(h_edge));
  vga_edge_detect u_v_edge (.mCLK(mCLK), .iRST_N(iRST_N), .sync(iVGA_V_SYNC), .fall(v_edge));

  // A pending or same-cycle V edge restarts the line count at the next H edge.
  assign v_restart = h_edge & (v_pend | v_edge);
  assign h_sat     = (h_cnt == CNT_MAX);
  assign v_sat     = (v_cnt == CNT_MAX);
  assign h_per     = h_sat ? CNT_MAX : h_cnt + cnt_t'(1);
  assign v_per     = v_sat ? CNT_MAX : v_cnt + cnt_t'(1);
  assign frame_ok  = ref_vld && (v_per >= Y_HI) && (ref_h >= X_HI);
  assign fault     = h_sat || v_sat || (h_edge && (h_per != ref_h))
                     || (v_restart && (v_per != ref_v));

  assign in_win = (h_cnt >= X_LO) && (h_cnt < X_HI) && (v_cnt >= Y_LO) && (v_cnt < Y_HI);
  assign pix_ok = (state == LOCKED) && !fault && in_win;
  assign x_c    = 10'(h_cnt - X_LO);
  assign y_c    = 10'(v_cnt - Y_LO);
  assign first  = (x_c == '0) && (y_c == '0);

  always_ff @(posedge mCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rgb_s1 <= '0;
      rgb_s2 <= '0;
    end else begin
      rgb_s1 <= {iVGA_R, iVGA_G, iVGA_B};
      rgb_s2 <= rgb_s1;
    end
  end

  always_ff @(posedge mCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      v_pend   <= 1'b0;
      oH_Total <= '0;
      oV_Total <= '0;
    end else begin
      if (h_edge) begin
        h_cnt    <= '0;
        oH_Total <= h_per;
      end else if (!h_sat) begin
        h_cnt <= h_cnt + cnt_t'(1);
      end
      if (v_restart) begin
        v_cnt    <= '0;
        oV_Total <= v_per;
        v_pend   <= 1'b0;
      end else begin
        if (v_edge) v_pend <= 1'b1;
        if (h_edge && !v_sat) v_cnt <= v_cnt + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge mCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= SEARCH;
      oLocked <= 1'b0;
      ref_h   <= '0;
      ref_v   <= '0;
      ref_vld <= 1'b0;
      good    <= '0;
    end else begin
      case (state)
        SEARCH: begin
          if (v_restart) begin
            state   <= MEASURE;
            good    <= '0;
            ref_vld <= 1'b0;
          end
        end
        MEASURE: begin
          if (h_sat || v_sat || (h_edge && ref_vld && (h_per != ref_h))) begin
            state <= SEARCH;
          end else if (v_restart) begin
            // Frames after the first must repeat the first frame's line count.
            if (!frame_ok || ((good != 8'd0) && (v_per != ref_v))) begin
              state <= SEARCH;
            end else begin
              good  <= good + 8'd1;
              ref_v <= v_per;
              if ((good + 8'd1) >= LOCK_N) begin
                state   <= LOCKED;
                oLocked <= 1'b1;
              end
            end
          end else if (h_edge && !ref_vld) begin
            ref_h   <= h_per;
            ref_vld <= 1'b1;
          end
        end
        LOCKED: begin
          if (fault) begin
            state   <= SEARCH;
            oLocked <= 1'b0;
          end
        end
        default: begin
          state   <= SEARCH;
          oLocked <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge mCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oPix_Valid   <= 1'b0;
      oFrame_Start <= 1'b0;
      oPix_R       <= '0;
      oPix_G       <= '0;
      oPix_B       <= '0;
      oCoord_X     <= '0;
      oCoord_Y     <= '0;
      oAddress     <= '0;
    end else begin
      oPix_Valid   <= pix_ok;
      oFrame_Start <= pix_ok && first;
      if (pix_ok) begin
        {oPix_R, oPix_G, oPix_B} <= rgb_s2;
        oCoord_X <= x_c;
        oCoord_Y <= y_c;
        oAddress <= (first || (oAddress == ADDR_MAX)) ? '0 : oAddress + 19'd1;
      end
    end
  end

endmodule
